// File: rtl/norm_pkg.sv
// Shared types and widths for the iterative normalizer (CLZ / CLS).
package norm_pkg;

  localparam int NORM_W  = 32;
  localparam int NORM_CW = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } norm_state_t;

endpackage

// File: rtl/norm_step.sv
// Per-cycle normalization decision: is the current value already normalized,
// is it a degenerate operand (zero / all sign bits), and the next shifted value.
module norm_step
  import norm_pkg::*;
(
  input  logic [NORM_W-1:0] sh,
  input  logic              arith,
  output logic              is_norm,
  output logic              is_degenerate,
  output logic [NORM_W-1:0] next_sh
);

  // Signed mode normalizes when the top two bits differ; unsigned when the MSB is set.
  always_comb begin
    is_norm       = 1'b0;
    is_degenerate = 1'b0;
    next_sh       = sh << 1;
    if (arith) begin
      is_norm       = sh[NORM_W-1] ^ sh[NORM_W-2];
      is_degenerate = (sh == '0) || (sh == '1);
    end else begin
      is_norm       = sh[NORM_W-1];
      is_degenerate = (sh == '0);
    end
  end

endmodule

// File: rtl/norm_unit.sv
// Iterative normalizer: shifts the operand left one bit per clock until it is
// normalized, reporting the shift amount (CLZ for unsigned, CLS for signed).
module norm_unit
  import norm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NORM_W-1:0]  src,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [NORM_W-1:0]  result,
  output logic [NORM_CW-1:0] count,
  output logic               zf
);

  norm_state_t        state_q;
  logic [NORM_W-1:0]  sh_q;
  logic [4:0]         cnt_q;
  logic               arith_q;
  logic               busy_q;
  logic               done_q;
  logic [NORM_W-1:0]  result_q;
  logic [NORM_CW-1:0] count_q;
  logic               zf_q;

  logic               is_norm;
  logic               is_degenerate;
  logic [NORM_W-1:0]  next_sh;
  logic [NORM_W-1:0]  degen_result;
  logic [NORM_CW-1:0] degen_count;

  norm_step u_step (
    .sh            (sh_q),
    .arith         (arith_q),
    .is_norm       (is_norm),
    .is_degenerate (is_degenerate),
    .next_sh       (next_sh)
  );

  // Degenerate operands are only possible on the first RUN cycle (shifting in
  // zeros can never create one), so sh still equals src here and src<<31 is
  // just the LSB moved to the top.
  always_comb begin
    degen_result = '0;
    degen_count  = 6'd32;
    if (arith_q) begin
      degen_result = {sh_q[0], {(NORM_W-1){1'b0}}};
      degen_count  = 6'd31;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      arith_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      count_q  <= '0;
      zf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            sh_q    <= src;
            cnt_q   <= '0;
            arith_q <= arith;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (is_degenerate) begin
            result_q <= degen_result;
            count_q  <= degen_count;
            zf_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (is_norm) begin
            result_q <= sh_q;
            count_q  <= {1'b0, cnt_q};
            zf_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            sh_q  <= next_sh;
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign count  = count_q;
  assign zf     = zf_q;

endmodule

// File: tb/tb_norm_unit.sv
// Self-checking bench for norm_unit: a cycle-level reference model plus
// directed operations with hand-computed results and latencies.
module tb_norm_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic        arith = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [5:0]  count;
  logic        zf;

  int checks = 0;
  int errors = 0;

  norm_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .src    (src),
    .arith  (arith),
    .busy   (busy),
    .done   (done),
    .result (result),
    .count  (count),
    .zf     (zf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a normalization must return, computed from the bit pattern.
  function automatic void model(input logic [31:0] s, input logic a,
                                output logic [31:0] r, output logic [5:0] c,
                                output logic z, output int n);
    int k;
    k = 0;
    if (!a) begin
      if (s == 32'h0) begin
        r = 32'h0; c = 6'd32; z = 1'b1; n = 0;
      end else begin
        while (k < 32 && s[31-k] == 1'b0) k++;
        r = s << k; c = 6'(k); z = 1'b0; n = k;
      end
    end else begin
      if (s == 32'h0 || s == 32'hFFFF_FFFF) begin
        r = s << 31; c = 6'd31; z = 1'b1; n = 0;
      end else begin
        while (s[30-k] == s[31]) k++;
        r = s << k; c = 6'(k); z = 1'b0; n = k;
      end
    end
  endfunction

  // Cycle-level model: tracks busy/done timing as an edge countdown.
  logic        m_busy = 0, m_done = 0, m_zf = 0;
  logic [31:0] m_res = '0;
  logic [5:0]  m_cnt = '0;
  logic [31:0] p_res;
  logic [5:0]  p_cnt;
  logic        p_zf;
  int          rem = 0;
  int          p_n;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_res = '0; m_cnt = '0; m_zf = 0; rem = 0;
      chk_en = 1;
    end else if (m_busy) begin
      rem--;
      if (rem == 0) begin
        m_busy = 0; m_done = 1; m_res = p_res; m_cnt = p_cnt; m_zf = p_zf;
      end
    end else begin
      m_done = 0;
      if (start) begin
        model(src, arith, p_res, p_cnt, p_zf, p_n);
        rem = p_n + 1;
        m_busy = 1;
      end
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("result", result, m_res);
      chk("count", 32'(count), 32'(m_cnt));
      chk("zf", 32'(zf), 32'(m_zf));
    end
  end

  task automatic run_op(input logic [31:0] s, input logic a, input logic [31:0] er,
                        input logic [5:0] ec, input logic ez, input int elat,
                        input bit mid_start);
    int lat;
    bit got;
    @(posedge clk); #1 src = s; arith = a; start = 1;
    @(posedge clk); #1 start = 0; src = ~s; arith = ~a;
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1;
      else if (mid_start && lat == 4) begin start = 1; src = 32'h0000_FFFF; end
      else if (mid_start && lat == 6) start = 0;
    end
    start = 0;
    chk($sformatf("latency %h/%0d", s, a), 32'(lat), 32'(elat));
    chk($sformatf("lit_result %h/%0d", s, a), result, er);
    chk($sformatf("lit_count %h/%0d", s, a), 32'(count), 32'(ec));
    chk($sformatf("lit_zf %h/%0d", s, a), 32'(zf), 32'(ez));
  endtask

  task automatic held_start(input logic [31:0] s, input logic a, input int cycles, input int edones);
    int nd;
    int w;
    @(posedge clk); #1 src = s; arith = a; start = 1;
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); @(negedge clk);
      if (done) nd++;
    end
    #1 start = 0;
    chk($sformatf("held_done_pulses %h", s), 32'(nd), 32'(edones));
    w = 0;
    while ((busy || done) && w < 60) begin
      @(negedge clk); w++;
    end
    chk("held_drain", 32'(busy || done), 32'h0);
  endtask

  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_result", result, 32'h0);
    chk("reset_count", 32'(count), 32'h0);

    run_op(32'h0001_0000, 0, 32'h8000_0000, 6'd15, 0, 16, 0);
    run_op(32'hFFFF_8000, 1, 32'h8000_0000, 6'd16, 0, 17, 0);
    run_op(32'h0000_4000, 1, 32'h4000_0000, 6'd16, 0, 17, 0);
    run_op(32'h0000_0000, 0, 32'h0000_0000, 6'd32, 1, 1, 0);
    run_op(32'hFFFF_FFFF, 1, 32'h8000_0000, 6'd31, 1, 1, 0);
    run_op(32'h8000_0000, 0, 32'h8000_0000, 6'd0, 0, 1, 0);
    run_op(32'h0000_0000, 1, 32'h0000_0000, 6'd31, 1, 1, 0);
    run_op(32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 6'd0, 0, 1, 0);
    run_op(32'h8000_0000, 1, 32'h8000_0000, 6'd0, 0, 1, 0);
    run_op(32'h0000_0001, 1, 32'h4000_0000, 6'd30, 0, 31, 0);
    run_op(32'h0000_0001, 0, 32'h8000_0000, 6'd31, 0, 32, 0);
    run_op(32'h0000_0001, 0, 32'h8000_0000, 6'd31, 0, 32, 1);

    // start held: 16-cycle ops re-accepted in each DONE cycle
    held_start(32'h0001_0000, 0, 40, 2);
    // back-to-back normalized ops: one done every 2 cycles
    held_start(32'h8000_0000, 0, 10, 5);

    // reset during RUN discards the operation
    @(posedge clk); #1 src = 32'h0000_0001; arith = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (9) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_done", 32'(done), 32'h0);
    chk("rst_mid_result", result, 32'h0);
    chk("rst_mid_count", 32'(count), 32'h0);
    chk("rst_mid_zf", 32'(zf), 32'h0);
    repeat (3) @(posedge clk);
    run_op(32'h0000_0100, 0, 32'h8000_0000, 6'd23, 0, 24, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
